// File: rtl/fpu_rshift_iter.sv
// fpu_rshift_iter: iterative multicycle logical right shifter (denormalizer).
// Shifts at most STEP bits per cycle and ORs every bit shifted out into Sticky.
// Used to align significands before rounding (subnormals, int conversion,
// operand alignment) when a full WIDTH barrel shifter is too large.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Flush                 abort the operation in flight (no result produced)
//   InValid/InReady       input handshake for ShiftIn/ShiftAmt
//   ShiftIn               value to shift right (logical)
//   ShiftAmt              shift amount; values above WIDTH saturate to WIDTH
//   OutValid/OutReady     output handshake for Shifted/Sticky
//   Shifted               ShiftIn >> ShiftAmt
//   Sticky                OR of all bits shifted out
//   Busy                  an operation is in flight (state != IDLE)
module fpu_rshift_iter #(
    parameter  int unsigned WIDTH    = 64,
    parameter  int unsigned STEP     = 8,
    localparam int unsigned LOGWIDTH = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Flush,
    input  logic                InValid,
    output logic                InReady,
    input  logic [WIDTH-1:0]    ShiftIn,
    input  logic [LOGWIDTH:0]   ShiftAmt,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [WIDTH-1:0]    Shifted,
    output logic                Sticky,
    output logic                Busy
);

    localparam logic [LOGWIDTH:0] WIDTH_L = (LOGWIDTH+1)'(WIDTH);
    localparam logic [LOGWIDTH:0] STEP_L  = (LOGWIDTH+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   data;
    logic               sticky_q;
    logic [LOGWIDTH:0]  rem;

    logic               accept;
    logic [LOGWIDTH:0]  amt_clamp;
    logic [LOGWIDTH:0]  step_amt;
    logic [LOGWIDTH:0]  rem_nxt;
    logic [WIDTH-1:0]   data_sh;
    logic               lost;

    assign accept    = InValid & InReady;
    assign amt_clamp = (ShiftAmt > WIDTH_L) ? WIDTH_L : ShiftAmt;
    assign step_amt  = (rem > STEP_L) ? STEP_L : rem;
    assign rem_nxt   = rem - step_amt;

    // Per-cycle shifter: a mux over the STEP+1 possible distances rather than
    // a full barrel shifter. lost collects the bits that fall off the bottom.
    always_comb begin
        data_sh = data;
        lost    = 1'b0;
        for (int unsigned i = 0; i <= STEP; i++) begin
            if (step_amt == (LOGWIDTH+1)'(i)) begin
                data_sh = data >> i;
                lost    = |(data & ~({WIDTH{1'b1}} << i));
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; Flush overrides every transition
    always_comb begin
        state_nxt = state;
        if (Flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:  if (accept) state_nxt = (amt_clamp == '0) ? DONE : SHIFT;
                SHIFT: if (rem_nxt == '0) state_nxt = DONE;
                DONE:  if (OutReady) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        InReady  = (state == IDLE) & ~reset & ~Flush;
        OutValid = (state == DONE);
        Busy     = (state != IDLE);
    end

    // Datapath; a flushed cycle leaves the registers untouched (not cleared)
    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= '0;
            sticky_q <= 1'b0;
            rem      <= '0;
        end else if (!Flush) begin
            if (accept) begin
                data     <= ShiftIn;
                sticky_q <= 1'b0;
                rem      <= amt_clamp;
            end else if (state == SHIFT) begin
                data     <= data_sh;
                sticky_q <= sticky_q | lost;
                rem      <= rem_nxt;
            end
        end
    end

    assign Shifted = data;
    assign Sticky  = sticky_q;

endmodule

// File: tb/tb_fpu_rshift_iter.sv
// Testbench for fpu_rshift_iter: scoreboard of expected results pushed on
// acceptance, checked by an independent monitor on the output handshake.
module tb_fpu_rshift_iter;

    localparam int unsigned W  = 64;
    localparam int unsigned ST = 8;
    localparam int unsigned LW = $clog2(W);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Flush = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [W-1:0]  ShiftIn = '0;
    logic [LW:0]   ShiftAmt = '0;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  Shifted;
    logic          Sticky;
    logic          Busy;

    fpu_rshift_iter #(.WIDTH(W), .STEP(ST)) dut (
        .clk      (clk),
        .reset    (reset),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .ShiftIn  (ShiftIn),
        .ShiftAmt (ShiftAmt),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Shifted  (Shifted),
        .Sticky   (Sticky),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sh;
        logic         st;
        int unsigned  due;
    } exp_t;
    exp_t q[$];

    logic rand_rdy = 1'b0;
    logic ready_force = 1'b1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Reference: full-width logical shift with explicit saturation
    function automatic void model(input logic [W-1:0] d, input int unsigned amt,
                                  output logic [W-1:0] sh, output logic st,
                                  output int unsigned lat);
        int unsigned a;
        a = (amt > W) ? W : amt;
        if (a == W) begin
            sh = '0;
            st = |d;
        end else if (a == 0) begin
            sh = d;
            st = 1'b0;
        end else begin
            sh = d >> a;
            st = |(d << (W - a));
        end
        lat = 1 + (a + ST - 1) / ST;
    endfunction

    // Consumer ready: either directed or random
    initial begin
        OutReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            OutReady = rand_rdy ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (reset || (Flush && Busy)) begin
            q.delete();
            prev_ov = 1'b0;
        end else if (OutValid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_outvalid: got OutValid=1 expected 0 (Shifted=%h)", Shifted);
            end else begin
                if (!prev_ov) check("latency", W'(cyc), W'(q[0].due));
                check("shifted", Shifted, q[0].sh);
                check("sticky", W'(Sticky), W'(q[0].st));
                if (OutReady) void'(q.pop_front());
            end
            prev_ov = OutValid & ~OutReady;
        end else begin
            prev_ov = 1'b0;
            if (q.size() > 0 && cyc > q[0].due) begin
                fail("result_late");
                void'(q.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] d, input int unsigned amt);
        exp_t        e;
        int unsigned lat;
        logic [W-1:0] sh;
        logic        st;
        bit          acc;
        acc = 0;
        @(posedge clk);
        #1;
        ShiftIn  = d;
        ShiftAmt = (LW+1)'(amt);
        InValid  = 1'b1;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge clk);
            if (InReady) begin
                model(d, amt, sh, st, lat);
                e.sh  = sh;
                e.st  = st;
                e.due = cyc + lat;
                q.push_back(e);
                acc = 1;
            end
        end
        if (!acc) fail("accept_timeout");
        @(posedge clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !Busy) done = 1;
        end
        if (!done) fail("idle_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        int unsigned  amt;
        int unsigned  r;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_inready", W'(InReady), '0);
        check("rst_outvalid", W'(OutValid), '0);
        check("rst_busy", W'(Busy), '0);
        check("rst_shifted", Shifted, '0);
        check("rst_sticky", W'(Sticky), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_inready", W'(InReady), 64'd1);

        // Directed cases
        issue(64'h8000_0000_0000_0001, 4);     wait_idle();
        issue(64'h0000_0000_0000_000F, 0);     wait_idle();
        issue(64'h0000_0000_0001_0000, 16);    wait_idle();
        issue(64'h0000_0000_0000_0001, 100);   wait_idle();
        issue(64'h0000_0000_0000_0000, 100);   wait_idle();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64);    wait_idle();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 63);    wait_idle();
        issue(64'h0000_0000_0000_00FF, 8);     wait_idle();
        issue(64'h0000_0000_0000_0100, 9);     wait_idle();

        // Back-pressure
        ready_force = 1'b0;
        issue(64'hDEAD_BEEF_0123_4567, 12);
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 50 && !seen; n++) begin
                @(negedge clk);
                if (OutValid) seen = 1;
            end
            if (!seen) fail("bp_outvalid_rise");
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            InValid  = 1'b1;
            ShiftIn  = {$urandom, $urandom};
            ShiftAmt = 7'd3;
            @(negedge clk);
            check("bp_inready", W'(InReady), '0);
            check("bp_outvalid", W'(OutValid), 64'd1);
        end
        @(posedge clk);
        #1;
        InValid = 1'b0;
        ready_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_inready", W'(InReady), 64'd1);
        check("bp_release_busy", W'(Busy), '0);
        check("bp_release_outvalid", W'(OutValid), '0);

        // Flush in the second SHIFT cycle
        issue(64'h1234_5678_9ABC_DEF0, 40);
        @(posedge clk);
        #1;
        Flush = 1'b1;
        @(negedge clk);
        check("flush_inready", W'(InReady), '0);
        check("flush_busy", W'(Busy), 64'd1);
        @(posedge clk);
        #1;
        Flush = 1'b0;
        @(negedge clk);
        check("post_flush_busy", W'(Busy), '0);
        check("post_flush_inready", W'(InReady), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flush_no_out", W'(OutValid), '0);
        end
        issue(64'h0000_0000_0000_00FF, 4);
        wait_idle();

        // Reset mid-SHIFT
        issue(64'hFFFF_0000_FFFF_0000, 40);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_inready", W'(InReady), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_outvalid", W'(OutValid), '0);
        check("midrst_shifted", Shifted, '0);
        check("midrst_sticky", W'(Sticky), '0);
        check("midrst_busy", W'(Busy), '0);
        check("midrst_inready_after", W'(InReady), 64'd1);

        // Randomized traffic with random back-pressure and occasional flushes
        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      amt = $urandom_range(64, 127);
            else if (r == 1) amt = 0;
            else             amt = $urandom_range(1, 63);
            d = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(0, 63);
            issue(d, amt);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                Flush = 1'b1;
                @(posedge clk);
                #1;
                Flush = 1'b0;
            end
        end
        rand_rdy = 1'b0;
        ready_force = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
